// File: rtl/ifsram_rd_if.sv
// Output stream of the ifmap SRAM reader: valid/ready words with row/window end tags.
interface ifsram_rd_if #(
    parameter int unsigned TBITS = 64
) ();
    logic             out_valid;
    logic             out_ready;
    logic [TBITS-1:0] out_data;
    logic             out_row_last;
    logic             out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_row_last,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_row_last,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/ifsram_rd.sv
// Streams a window of ifmap rows out of one SRAM bank into a 3-deep valid/ready FIFO,
// absorbing the one-cycle SRAM read latency.
module ifsram_rd #(
    parameter int unsigned TBITS              = 64,
    parameter int unsigned IFMAP_SRAM_ADDBITS = 11,
    parameter int unsigned NBANK              = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rd_start,
    output logic                          rd_busy,
    output logic                          rd_done,
    input  logic [2:0]                    cfg_bank_sel,
    input  logic [2:0]                    cfg_row_num,
    input  logic [2:0]                    cfg_cnt_step,
    input  logic [IFMAP_SRAM_ADDBITS-1:0] cfg_row_list_0,
    input  logic [IFMAP_SRAM_ADDBITS-1:0] cfg_row_list_1,
    input  logic [IFMAP_SRAM_ADDBITS-1:0] cfg_row_list_2,
    input  logic [IFMAP_SRAM_ADDBITS-1:0] cfg_row_list_3,
    input  logic [IFMAP_SRAM_ADDBITS-1:0] cfg_row_list_4,
    output logic [NBANK-1:0]              rdb_cen,
    output logic [NBANK-1:0]              rdb_wen,
    output logic [IFMAP_SRAM_ADDBITS-1:0] rdb_addr,
    input  logic [NBANK*TBITS-1:0]        rdb_q,
    ifsram_rd_if.master                   out_if
);

    localparam int unsigned AW    = IFMAP_SRAM_ADDBITS;
    localparam int unsigned DEPTH = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e                    state_q, state_d;
    logic [2:0]                bank_q, bank_d;
    logic [2:0]                row_num_q, row_num_d;
    logic [2:0]                cnt_step_q, cnt_step_d;
    logic [4:0][AW-1:0]        row_list_q, row_list_d;
    logic [2:0]                row_q, row_d;
    logic [2:0]                step_q, step_d;
    logic                      issue_q, issue_d;
    logic                      iss_rl_q, iss_rl_d;
    logic                      iss_last_q, iss_last_d;
    logic                      inflight_q, inflight_d;
    logic                      inf_rl_q, inf_rl_d;
    logic                      inf_last_q, inf_last_d;
    logic [NBANK-1:0]          cen_q, cen_d;
    logic [AW-1:0]             addr_q, addr_d;
    logic [DEPTH-1:0][TBITS-1:0] fd_q, fd_d;
    logic [DEPTH-1:0]          frl_q, frl_d;
    logic [DEPTH-1:0]          fl_q, fl_d;
    logic [1:0]                cnt_q, cnt_d;
    logic                      valid_q, valid_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic                      start;
    logic                      push;
    logic                      pop;
    logic [1:0]                cnt_pop;
    logic [TBITS-1:0]          q_sel;
    logic [2:0]                eff_bank;
    logic [2:0]                eff_row_num;
    logic [2:0]                eff_cnt_step;
    logic [2:0]                eff_row;
    logic [2:0]                eff_step;
    logic [4:0][AW-1:0]        eff_list;
    logic                      eff_rl;

    // Next-state, issue and FIFO logic
    always_comb begin
        state_d      = state_q;
        bank_d       = bank_q;
        row_num_d    = row_num_q;
        cnt_step_d   = cnt_step_q;
        row_list_d   = row_list_q;
        row_d        = row_q;
        step_d       = step_q;
        issue_d      = 1'b0;
        iss_rl_d     = 1'b0;
        iss_last_d   = 1'b0;
        inflight_d   = issue_q;
        inf_rl_d     = iss_rl_q;
        inf_last_d   = iss_last_q;
        cen_d        = {NBANK{1'b1}};
        addr_d       = addr_q;
        fd_d         = fd_q;
        frl_d        = frl_q;
        fl_d         = fl_q;
        cnt_d        = cnt_q;
        valid_d      = valid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        start        = (state_q == S_IDLE) && rd_start;
        push         = inflight_q;
        pop          = valid_q && out_if.out_ready;
        cnt_pop      = cnt_q - 2'(pop);
        q_sel        = rdb_q[32'(bank_q)*TBITS +: TBITS];
        eff_bank     = bank_q;
        eff_row_num  = row_num_q;
        eff_cnt_step = cnt_step_q;
        eff_row      = row_q;
        eff_step     = step_q;
        eff_list     = row_list_q;
        eff_rl       = 1'b0;

        // On the start edge the first read uses the live cfg inputs
        if (start) begin
            eff_bank     = cfg_bank_sel;
            eff_row_num  = (cfg_row_num > 3'd4) ? 3'd4 : cfg_row_num;
            eff_cnt_step = cfg_cnt_step;
            eff_row      = 3'd0;
            eff_step     = 3'd0;
            eff_list     = {cfg_row_list_4, cfg_row_list_3, cfg_row_list_2,
                            cfg_row_list_1, cfg_row_list_0};
            bank_d       = eff_bank;
            row_num_d    = eff_row_num;
            cnt_step_d   = eff_cnt_step;
            row_list_d   = eff_list;
            row_d        = 3'd0;
            step_d       = 3'd0;
        end

        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                fd_d[i]  = fd_q[i+1];
                frl_d[i] = frl_q[i+1];
                fl_d[i]  = fl_q[i+1];
            end
        end
        if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (2'(i) == cnt_pop) begin
                    fd_d[i]  = q_sel;
                    frl_d[i] = inf_rl_q;
                    fl_d[i]  = inf_last_q;
                end
            end
        end
        cnt_d   = cnt_pop + 2'(push);
        valid_d = (cnt_d != 2'd0);

        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (issue_q && iss_last_q) state_d = S_DRAIN;
            S_DRAIN: if (!inflight_q && (cnt_d == 2'd0)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Issue decided one edge early against next cycle's FIFO count plus inflight read
        issue_d = (state_d == S_RUN) && ((3'(cnt_d) + 3'(issue_q)) < 3'(DEPTH));
        if (issue_d) begin
            eff_rl     = (eff_step == eff_cnt_step);
            cen_d      = ~(NBANK'(1) << eff_bank);
            addr_d     = AW'(eff_list[eff_row] + AW'(eff_step));
            iss_rl_d   = eff_rl;
            iss_last_d = eff_rl && (eff_row == eff_row_num);
            if (eff_rl) begin
                step_d = 3'd0;
                row_d  = eff_row + 3'd1;
            end else begin
                step_d = eff_step + 3'd1;
                row_d  = eff_row;
            end
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            bank_q     <= 3'd0;
            row_num_q  <= 3'd0;
            cnt_step_q <= 3'd0;
            row_list_q <= '0;
            row_q      <= 3'd0;
            step_q     <= 3'd0;
            issue_q    <= 1'b0;
            iss_rl_q   <= 1'b0;
            iss_last_q <= 1'b0;
            inflight_q <= 1'b0;
            inf_rl_q   <= 1'b0;
            inf_last_q <= 1'b0;
            cen_q      <= {NBANK{1'b1}};
            addr_q     <= '0;
            fd_q       <= '0;
            frl_q      <= '0;
            fl_q       <= '0;
            cnt_q      <= 2'd0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bank_q     <= bank_d;
            row_num_q  <= row_num_d;
            cnt_step_q <= cnt_step_d;
            row_list_q <= row_list_d;
            row_q      <= row_d;
            step_q     <= step_d;
            issue_q    <= issue_d;
            iss_rl_q   <= iss_rl_d;
            iss_last_q <= iss_last_d;
            inflight_q <= inflight_d;
            inf_rl_q   <= inf_rl_d;
            inf_last_q <= inf_last_d;
            cen_q      <= cen_d;
            addr_q     <= addr_d;
            fd_q       <= fd_d;
            frl_q      <= frl_d;
            fl_q       <= fl_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign rd_busy             = busy_q;
    assign rd_done             = done_q;
    assign rdb_cen             = cen_q;
    assign rdb_wen             = {NBANK{1'b1}};
    assign rdb_addr            = addr_q;
    assign out_if.out_valid    = valid_q;
    assign out_if.out_data     = fd_q[0];
    assign out_if.out_row_last = frl_q[0];
    assign out_if.out_last     = fl_q[0];

endmodule
